// File: rtl/pipe_hazard_if.sv
// Decode/execute hazard bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_if #(
    parameter int unsigned RA_W  = 3,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic             id_we;
    logic [RA_W-1:0]  id_wd;
    logic             id_load;
    logic             ex_br_taken;
    logic             mem_wait;
    logic             stall;
    logic             flush;
    logic [3:0]       fwd1;
    logic [3:0]       fwd2;
    logic [DEPTH-1:0] slot_vld;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_we, id_wd, id_load,
               ex_br_taken, mem_wait,
        input  stall, flush, fwd1, fwd2, slot_vld, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_we, id_wd, id_load,
               ex_br_taken, mem_wait,
        output stall, flush, fwd1, fwd2, slot_vld, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// In-order pipeline hazard controller: tracks writers in the stages after decode, selects
// forwarding sources, detects load-use stalls, handles branch flush and memory freeze.
module pipe_hazard_ctrl #(
    parameter int unsigned RA_W     = 3,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_RDY = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    pipe_hazard_if.slave hz
);

    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LOAD_RDY_K = 4'(LOAD_RDY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_hazard_ctrl: DEPTH must be in 2..8");
    end
    if (LOAD_RDY < 1 || LOAD_RDY > DEPTH) begin : g_bad_load_rdy
        $error("pipe_hazard_ctrl: LOAD_RDY must be in 1..DEPTH");
    end

    // Slot k lives at index k-1 (index 0 = execute).
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] we_q, we_d;
    logic [DEPTH-1:0] load_q, load_d;
    logic [RA_W-1:0]  wd_q [DEPTH];
    logic [RA_W-1:0]  wd_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [3:0] win1, win2;
    logic       win1_load, win2_load;
    logic       load_use_c;
    logic       flush_c;
    logic       stall_c;

    // Scan oldest to youngest so the youngest matching slot overwrites the winner.
    always_comb begin
        win1      = '0;
        win2      = '0;
        win1_load = 1'b0;
        win2_load = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hz.id_use1 && vld_q[IDX_W'(k-1)] && we_q[IDX_W'(k-1)]
                && (wd_q[IDX_W'(k-1)] == hz.id_rs1)) begin
                win1      = 4'(k);
                win1_load = load_q[IDX_W'(k-1)];
            end
            if (hz.id_use2 && vld_q[IDX_W'(k-1)] && we_q[IDX_W'(k-1)]
                && (wd_q[IDX_W'(k-1)] == hz.id_rs2)) begin
                win2      = 4'(k);
                win2_load = load_q[IDX_W'(k-1)];
            end
        end
    end

    // Memory freeze dominates branch flush; flush dominates the load-use stall.
    always_comb begin
        load_use_c = hz.id_valid && ((win1_load && (win1 < LOAD_RDY_K))
                                  || (win2_load && (win2 < LOAD_RDY_K)));
        flush_c    = hz.ex_br_taken && !hz.mem_wait;
        stall_c    = (load_use_c || hz.mem_wait) && !flush_c;
    end

    always_comb begin
        vld_d       = vld_q;
        we_d        = we_q;
        load_d      = load_q;
        wd_d        = wd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hz.mem_wait) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                vld_d[IDX_W'(k)]  = vld_q[IDX_W'(k-1)];
                we_d[IDX_W'(k)]   = we_q[IDX_W'(k-1)];
                load_d[IDX_W'(k)] = load_q[IDX_W'(k-1)];
                wd_d[IDX_W'(k)]   = wd_q[IDX_W'(k-1)];
            end
            if (flush_c || load_use_c) begin
                vld_d[0]  = 1'b0;
                we_d[0]   = 1'b0;
                load_d[0] = 1'b0;
                wd_d[0]   = '0;
            end else begin
                vld_d[0]  = hz.id_valid;
                we_d[0]   = hz.id_we;
                load_d[0] = hz.id_load;
                wd_d[0]   = hz.id_wd;
            end
            if (load_use_c && !flush_c && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush_c && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q       <= '0;
            we_q        <= '0;
            load_q      <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                wd_q[k] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            we_q        <= we_d;
            load_q      <= load_d;
            wd_q        <= wd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall     = stall_c;
    assign hz.flush     = flush_c;
    assign hz.fwd1      = (stall_c || flush_c) ? 4'd0 : win1;
    assign hz.fwd2      = (stall_c || flush_c) ? 4'd0 : win2;
    assign hz.slot_vld  = vld_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter RA_W, default 3, register-address width (2**RA_W architectural registers).
REQ-002 Parameter DEPTH, default 3, tracked stages after decode; slot 1 = execute, slot DEPTH = writeback; legal range 2..8.
REQ-003 Parameter LOAD_RDY, default 2, first slot at which load data is forwardable; legal range 1..DEPTH.
REQ-004 Parameter CNT_W, default 16, performance-counter width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 id_valid  in  1  valid instruction in decode.
REQ-008 id_rs1, id_rs2  in  RA_W each  decode source registers.
REQ-009 id_use1, id_use2  in  1 each  the corresponding source is read.
REQ-010 id_we  in  1  decode instruction writes a register.
REQ-011 id_wd  in  RA_W  decode destination register.
REQ-012 id_load  in  1  decode instruction is a load.
REQ-013 ex_br_taken  in  1  slot-1 instruction is a taken branch.
REQ-014 mem_wait  in  1  memory not ready; freezes the whole pipeline.
REQ-015 stall  out  1  hold fetch and decode this cycle.
REQ-016 flush  out  1  discard the fetch and decode contents this cycle.
REQ-017 fwd1, fwd2  out  4 each  forward source per operand; 0 = register file, k = slot k.
REQ-018 slot_vld  out  DEPTH  per-slot valid vector, bit k-1 = slot k.
REQ-019 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-020 Each slot SHALL hold {vld, we, wd, load}, shifting slot k to k+1 each non-frozen cycle; slot DEPTH retires.
REQ-021 Operand n SHALL match slot k iff id_usen, slot vld, slot we and slot wd == id_rsn; the lowest matching k (youngest) SHALL win.
REQ-022 fwdn SHALL equal the winning k, else 0; when stall=1 or flush=1, fwd1 and fwd2 SHALL be 0.
REQ-023 Load-use hazard: id_valid=1, winning slot of either operand has load=1, and k < LOAD_RDY.
REQ-024 stall SHALL be combinational: (load-use hazard or mem_wait) and not flush-override (REQ-027).
REQ-025 On load-use stall without mem_wait: slots shift; slot 1 loads a bubble (vld=0).
REQ-026 mem_wait=1: all slots hold, stall=1, flush=0 regardless of ex_br_taken, counters hold.
REQ-027 ex_br_taken=1 with mem_wait=0: flush=1 and stall=0 the same cycle; slot 1 loads a bubble next edge.
REQ-028 Otherwise slot 1 SHALL load {id_valid, id_we, id_wd, id_load}.
REQ-029 stall_cnt SHALL increment on each load-use stall cycle with mem_wait=0; flush_cnt on each flush cycle; both saturate at all-ones.
REQ-030 Register 0 is an ordinary register; no special-casing.
REQ-031 Latency: stall, flush and fwd are combinational from inputs and current slot state; slot state updates one edge later.

Reset
REQ-032 While reset=1: all slots vld=0, stall_cnt=flush_cnt=0, slot_vld=0, immediately and asynchronously.
REQ-033 After reset deassertion, with no valid slot, stall=0, flush=0, fwd1=fwd2=0 for any decode input.
REQ-034 Reset asserted mid-stall or mid-flush SHALL abort it with no residual bubble or count.

Verification
REQ-035 ADD writes R3, next instruction reads R3 on rs1 -> fwd1=1, stall=0; one cycle later with a gap, fwd1=2.
REQ-036 LD writes R2 (defaults), next reads R2 on rs2 -> stall=1 one cycle, slot_vld=3'b010 after edge, then fwd2=2, stall_cnt=1.
REQ-037 Slots 1 and 2 both write R5, decode reads R5 -> fwd1=1 (youngest wins).
REQ-038 ex_br_taken=1 while load-use hazard present -> flush=1, stall=0, flush_cnt=1, stall_cnt=0, slot 1 bubble.
REQ-039 mem_wait=1 for 3 cycles with ex_br_taken=1 -> stall=1, flush=0, slot state and counters unchanged throughout.
REQ-040 CNT_W=2, 5 consecutive load-use stalls -> stall_cnt saturates at 3; reset mid-sequence -> all outputs 0.
